bus_master_port: RTL

- Master-side transaction controller for the system bus. It sits between a master's local logic and the shared bus/arbiter.
- It accepts one parallel read or write command, requests the bus from the arbiter and waits for grant. It then shifts the address and data serially over the bus lines, and returns read data or an error status to the local side.
- One instance is used per master (M1, M2).

---
 rtl/sysbus_pkg.sv | 32 +++
 rtl/bus_bit_serializer.sv | 36 +++
 rtl/bus_master_port.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: slave ids, arbiter grant codes, master FSM states
// and default widths for the master port.
package sysbus_pkg;

  typedef enum logic [1:0] {
    SLV0     = 2'd0,
    SLV1     = 2'd1,
    SLV2     = 2'd2,
    SLV_RSVD = 2'd3
  } slave_id_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M1   = 2'b01,
    GNT_M2   = 2'b10
  } bus_grant_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WAIT_RDY,
    WDATA,
    RDATA,
    DONE
  } mst_state_t;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/bus_bit_serializer.sv
// LSB-first shift register with a bit counter; 'last' flags the final bit of an
// nbits-long frame. Used both to send (serial_out = shreg[0]) and to receive.
module bus_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [CNT_W-1:0] nbits,
  output logic [WIDTH-1:0] shreg,
  output logic             last
);

  logic [CNT_W-1:0] bitcnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bitcnt_reg <= '0;
    end else if (load) begin
      shreg      <= load_data;
      bitcnt_reg <= '0;
    end else if (shift_en) begin
      // New bits enter at the top so the first received bit ends up in bit 0.
      shreg      <= {serial_in, shreg[WIDTH-1:1]};
      bitcnt_reg <= bitcnt_reg + CNT_W'(1);
    end
  end

  assign last = (bitcnt_reg == nbits - CNT_W'(1));

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus transaction controller: latches one command, arbitrates for the
// bus, shifts address/data serially and reports read data or an abort status.
module bus_master_port
  import sysbus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        slave_id,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              m_request,
  output logic [1:0]        m_slave_sel,
  input  logic              m_grant,
  output logic              bus_valid,
  output logic              bus_rw,
  output logic              bus_addr,
  output logic              bus_wdata,
  input  logic              slave_ready,
  input  logic              slave_valid,
  input  logic              bus_rdata
);

  localparam int TX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int TX_CW = $clog2(TX_W + 1);
  localparam int RX_CW = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  mst_state_t        state_reg, state_next;
  logic              err_next;
  logic              rw_reg;
  logic [1:0]        sid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [TO_W-1:0]   tcnt_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              timeout;

  logic              tx_load, tx_shift, tx_last;
  logic [TX_W-1:0]   tx_data, tx_shreg;
  logic [TX_CW-1:0]  tx_nbits;
  logic              rx_load, rx_shift, rx_last;
  logic [DATA_W-1:0] rx_shreg;
  logic              unused_ok;

  assign timeout = (tcnt_reg == TO_W'(TIMEOUT - 1));

  // One TX shifter carries the address, then is reloaded with write data.
  assign tx_load  = m_grant && ((state_reg == REQ) || (state_reg == ADDR && tx_last));
  assign tx_data  = (state_reg == REQ) ? TX_W'(addr_reg) : TX_W'(wdata_reg);
  assign tx_shift = m_grant && (state_reg == ADDR || state_reg == WDATA);
  assign tx_nbits = (state_reg == ADDR) ? TX_CW'(ADDR_W) : TX_CW'(DATA_W);

  assign rx_load  = (state_reg == WAIT_RDY) && m_grant && slave_ready && !rw_reg;
  assign rx_shift = (state_reg == RDATA) && m_grant && slave_valid;

  bus_bit_serializer #(.WIDTH(TX_W), .CNT_W(TX_CW)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_data),
    .shift_en  (tx_shift),
    .serial_in (1'b0),
    .nbits     (tx_nbits),
    .shreg     (tx_shreg),
    .last      (tx_last)
  );

  bus_bit_serializer #(.WIDTH(DATA_W), .CNT_W(RX_CW)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (rx_load),
    .load_data ('0),
    .shift_en  (rx_shift),
    .serial_in (bus_rdata),
    .nbits     (RX_CW'(DATA_W)),
    .shreg     (rx_shreg),
    .last      (rx_last)
  );

  assign unused_ok = ^{tx_shreg[TX_W-1:1], rx_shreg[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (slave_id == SLV_RSVD) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: if (m_grant) state_next = ADDR;
      ADDR: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (tx_last) begin
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (!m_grant || (!slave_ready && timeout)) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (slave_ready) begin
          state_next = rw_reg ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (tx_last) begin
          state_next = DONE;
        end
      end
      RDATA: begin
        if (!m_grant || (!slave_valid && timeout)) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (slave_valid && rx_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_reg    <= 1'b0;
      sid_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      tcnt_reg  <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        rw_reg    <= rw;
        sid_reg   <= slave_id;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      // Idle-cycle counter: restarts on every state change and on each read bit.
      if (state_next != state_reg)
        tcnt_reg <= '0;
      else if (state_reg == WAIT_RDY || (state_reg == RDATA && !slave_valid))
        tcnt_reg <= tcnt_reg + TO_W'(1);
      else
        tcnt_reg <= '0;
      if (state_next == DONE && state_reg != DONE)
        err_reg <= err_next;
      if (rx_shift && rx_last)
        rdata_reg <= {bus_rdata, rx_shreg[DATA_W-1:1]};
    end
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    done        = (state_reg == DONE);
    err         = done && err_reg;
    m_request   = (state_reg == REQ) || (state_reg == ADDR) || (state_reg == WAIT_RDY) ||
                  (state_reg == WDATA) || (state_reg == RDATA);
    m_slave_sel = m_request ? sid_reg : 2'd0;
    bus_valid   = (state_reg == ADDR) || (state_reg == WDATA);
    bus_rw      = bus_valid && rw_reg;
    bus_addr    = (state_reg == ADDR) && tx_shreg[0];
    bus_wdata   = (state_reg == WDATA) && tx_shreg[0];
  end

  assign rdata = rdata_reg;

endmodule
